ir_nec_decoder: RTL

//  Decodes the demodulated IR receiver output (NEC protocol) into the 8-bit remote key code

---
 rtl/ir_nec_pkg.sv | 36 +++
 rtl/ir_tick_gen.sv | 31 +++
 rtl/ir_nec_decoder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR decoder: FSM encoding, pulse-width windows in
// 10 us ticks, tick counter saturation value and the idle key code.
package ir_nec_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_RPT_MARK,
        ST_CHECK,
        ST_ERR
    } state_t;

    localparam logic [9:0] TICK_SAT       = 10'd1023;
    localparam logic [7:0] NO_KEY_DEFAULT = 8'hFF;

    // All windows are inclusive at both ends
    localparam logic [9:0] LEAD_MARK_MIN  = 10'd800;
    localparam logic [9:0] LEAD_MARK_MAX  = 10'd1000;
    localparam logic [9:0] LEAD_DATA_MIN  = 10'd400;
    localparam logic [9:0] LEAD_DATA_MAX  = 10'd500;
    localparam logic [9:0] LEAD_RPT_MIN   = 10'd200;
    localparam logic [9:0] LEAD_RPT_MAX   = 10'd250;
    localparam logic [9:0] SHORT_MIN      = 10'd40;
    localparam logic [9:0] SHORT_MAX      = 10'd70;
    localparam logic [9:0] ONE_SPACE_MIN  = 10'd140;
    localparam logic [9:0] ONE_SPACE_MAX  = 10'd190;

    function automatic logic in_win(input logic [9:0] dur, input logic [9:0] lo, input logic [9:0] hi);
        return (dur >= lo) && (dur <= hi);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Prescaler that emits a one-cycle tick_en every CYCLES_PER_TICK clocks.
module ir_tick_gen #(
    parameter int CYCLES_PER_TICK = 500
) (
    input  logic clock,
    input  logic reset,
    output logic tick_en
);

    localparam int CW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_TICK - 1);

    logic [CW-1:0] div_reg;
    logic          tick_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (div_reg == LAST) begin
            div_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            div_reg  <= div_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign tick_en = tick_reg;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: synchronizes the receiver output, times each mark/space in
// 10 us ticks and reports key codes, repeat codes and malformed frames as strobes.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int         CYCLES_PER_TICK = 500,
    parameter int         IR_ACTIVE_LOW   = 1,
    parameter int         CHECK_ADDR_INV  = 0,
    parameter logic [7:0] NO_KEY          = NO_KEY_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ir_in,
    output logic [7:0] bot,
    output logic       bot_valid,
    output logic [7:0] address,
    output logic [7:0] cmd_last,
    output logic       repeat_p,
    output logic       error_p
);

    localparam logic IDLE_RAW = (IR_ACTIVE_LOW != 0);

    logic        tick_en;
    logic        sync1_reg, sync2_reg, mark_d_reg;
    logic        mark, edge_det, mark_start, mark_end;
    logic [9:0]  tick_cnt_reg;
    logic        sat;
    state_t      state_reg, state_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic [31:0] shift_reg, shift_next;
    logic [7:0]  frame_byte [4];
    logic        frame_ok;
    logic        do_valid, do_repeat, do_error;
    logic [7:0]  bot_reg, address_reg, cmd_last_reg;
    logic        bot_valid_reg, repeat_reg, error_reg;

    ir_tick_gen #(.CYCLES_PER_TICK(CYCLES_PER_TICK)) u_tick_gen (
        .clock   (clock),
        .reset   (reset),
        .tick_en (tick_en)
    );

    // Synchronizer resets to the idle line level so reset never fakes a mark edge
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg  <= IDLE_RAW;
            sync2_reg  <= IDLE_RAW;
            mark_d_reg <= 1'b0;
        end else begin
            sync1_reg  <= ir_in;
            sync2_reg  <= sync1_reg;
            mark_d_reg <= mark;
        end
    end

    assign mark       = sync2_reg ^ IDLE_RAW;
    assign edge_det   = mark ^ mark_d_reg;
    assign mark_start = edge_det & mark;
    assign mark_end   = edge_det & ~mark;

    always_ff @(posedge clock) begin
        if (reset || edge_det)
            tick_cnt_reg <= '0;
        else if (tick_en && !sat)
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end

    assign sat = (tick_cnt_reg == TICK_SAT);

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign frame_byte[gi] = shift_reg[gi*8 +: 8];
    end

    assign frame_ok = (frame_byte[3] == ~frame_byte[2]) &&
                      ((CHECK_ADDR_INV == 0) || (frame_byte[1] == ~frame_byte[0]));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
        end
    end

    // Edges take priority over saturation; a saturated duration fails every window anyway
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        do_valid     = 1'b0;
        do_repeat    = 1'b0;
        do_error     = 1'b0;
        unique case (state_reg)
            ST_IDLE: if (mark_start) state_next = ST_LEAD_MARK;
            ST_LEAD_MARK: begin
                if (mark_end)
                    state_next = in_win(tick_cnt_reg, LEAD_MARK_MIN, LEAD_MARK_MAX) ? ST_LEAD_SPACE : ST_IDLE;
                else if (sat)
                    state_next = ST_IDLE;
            end
            ST_LEAD_SPACE: begin
                if (mark_start) begin
                    if (in_win(tick_cnt_reg, LEAD_DATA_MIN, LEAD_DATA_MAX)) begin
                        state_next   = ST_BIT_MARK;
                        bit_cnt_next = '0;
                    end else if (in_win(tick_cnt_reg, LEAD_RPT_MIN, LEAD_RPT_MAX))
                        state_next = ST_RPT_MARK;
                    else
                        state_next = ST_IDLE;
                end else if (sat)
                    state_next = ST_ERR;
            end
            ST_BIT_MARK: begin
                if (mark_end)
                    state_next = in_win(tick_cnt_reg, SHORT_MIN, SHORT_MAX) ? ST_BIT_SPACE : ST_ERR;
                else if (sat)
                    state_next = ST_ERR;
            end
            ST_BIT_SPACE: begin
                if (mark_start) begin
                    if (in_win(tick_cnt_reg, SHORT_MIN, SHORT_MAX) ||
                        in_win(tick_cnt_reg, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                        shift_next   = {in_win(tick_cnt_reg, ONE_SPACE_MIN, ONE_SPACE_MAX), shift_reg[31:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        state_next   = (bit_cnt_reg == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                    end else
                        state_next = ST_ERR;
                end else if (sat)
                    state_next = ST_ERR;
            end
            ST_STOP_MARK: begin
                if (mark_end)
                    state_next = in_win(tick_cnt_reg, SHORT_MIN, SHORT_MAX) ? ST_CHECK : ST_ERR;
                else if (sat)
                    state_next = ST_ERR;
            end
            ST_RPT_MARK: begin
                if (mark_end) begin
                    if (in_win(tick_cnt_reg, SHORT_MIN, SHORT_MAX)) begin
                        do_repeat  = 1'b1;
                        state_next = ST_IDLE;
                    end else
                        state_next = ST_ERR;
                end else if (sat)
                    state_next = ST_ERR;
            end
            ST_CHECK: begin
                do_valid   = frame_ok;
                do_error   = ~frame_ok;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                do_error   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bot_reg       <= NO_KEY;
            bot_valid_reg <= 1'b0;
            address_reg   <= '0;
            cmd_last_reg  <= '0;
            repeat_reg    <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            bot_reg       <= do_valid ? frame_byte[2] : NO_KEY;
            bot_valid_reg <= do_valid;
            repeat_reg    <= do_repeat;
            error_reg     <= do_error;
            if (do_valid) begin
                address_reg  <= frame_byte[0];
                cmd_last_reg <= frame_byte[2];
            end
        end
    end

    assign bot       = bot_reg;
    assign bot_valid = bot_valid_reg;
    assign address   = address_reg;
    assign cmd_last  = cmd_last_reg;
    assign repeat_p  = repeat_reg;
    assign error_p   = error_reg;

endmodule
